// File: rtl/cpu_ad48_pkg.sv
// Shared CPU_AD48 definitions: CSR select/op encodings and interrupt controller FSM states.
// csr_apply implements the RW/RS/RC read-modify-write used by every IRQC CSR.
package cpu_ad48_pkg;

  localparam int unsigned CSR_W = 48;

  typedef enum logic [1:0] {
    CSR_PENDING = 2'd0,
    CSR_ENABLE  = 2'd1,
    CSR_MODE    = 2'd2,
    CSR_RSVD    = 2'd3
  } irqc_csr_sel_e;

  typedef enum logic [1:0] {
    CSR_OP_RW  = 2'd0,
    CSR_OP_RS  = 2'd1,
    CSR_OP_RC  = 2'd2,
    CSR_OP_NOP = 2'd3
  } irqc_csr_op_e;

  typedef enum logic [1:0] {
    IRQC_IDLE    = 2'd0,
    IRQC_REQ     = 2'd1,
    IRQC_SERVICE = 2'd2
  } irqc_state_e;

  function automatic logic [CSR_W-1:0] csr_apply(input logic [1:0] op,
                                                 input logic [CSR_W-1:0] cur,
                                                 input logic [CSR_W-1:0] wd);
    logic [CSR_W-1:0] res;
    case (op)
      CSR_OP_RW: res = wd;
      CSR_OP_RS: res = cur | wd;
      CSR_OP_RC: res = cur & ~wd;
      default:   res = cur;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cpu_ad48_irq_sync.sv
// Per-line interrupt synchronizer with a rising-edge detector on the synchronized output.
// rise_o is high for exactly one cycle after sync_o goes 0->1.
module cpu_ad48_irq_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic irq_i,
  output logic sync_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] chain_q, chain_d;
  logic                   prev_q, prev_d;

  // Shift the raw line into the chain; remember last sync value for edge detect
  always_comb begin
    chain_d = {chain_q[SYNC_STAGES-2:0], irq_i};
    prev_d  = chain_q[SYNC_STAGES-1];
  end

  // Synchronizer and edge-history flops
  always_ff @(posedge clk) begin
    if (!resetn) begin
      chain_q <= {SYNC_STAGES{1'b0}};
      prev_q  <= 1'b0;
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
    end
  end

  assign sync_o = chain_q[SYNC_STAGES-1];
  assign rise_o = chain_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/cpu_ad48_irqc.sv
// CPU_AD48 interrupt controller: pending/enable/mode CSRs, fixed lowest-index priority,
// and an IDLE/REQ/SERVICE handshake with the core (no nesting).
module cpu_ad48_irqc
  import cpu_ad48_pkg::*;
#(
  parameter int unsigned IRQ_LINES   = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [IRQ_LINES-1:0] irq_in,
  input  logic                 mie,
  input  logic                 csr_we,
  input  logic [1:0]           csr_sel,
  input  logic [1:0]           csr_op,
  input  logic [47:0]          csr_wdata,
  output logic [47:0]          csr_rdata,
  output logic                 irq_req,
  output logic [5:0]           irq_idx,
  input  logic                 irq_ack,
  input  logic                 irq_iret,
  output logic                 in_service
);

  logic [IRQ_LINES-1:0] sync_s, rise_s, active_s, sw_pend_s;
  logic [IRQ_LINES-1:0] pend_q, pend_d, en_q, en_d, mode_q, mode_d;
  irqc_state_e          state_q, state_d;
  logic                 irq_req_q, irq_req_d, in_service_q, in_service_d;
  logic [5:0]           irq_idx_q, irq_idx_d, cand_s;

  for (genvar g = 0; g < IRQ_LINES; g++) begin : g_line
    cpu_ad48_irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .resetn (resetn),
      .irq_i  (irq_in[g]),
      .sync_o (sync_s[g]),
      .rise_o (rise_s[g])
    );
  end

  // CSR updates; level lines mirror sync, an edge-set beats a same-cycle software clear
  always_comb begin
    en_d      = en_q;
    mode_d    = mode_q;
    sw_pend_s = pend_q;
    if (csr_we && (csr_sel == CSR_ENABLE)) begin
      en_d = IRQ_LINES'(csr_apply(csr_op, CSR_W'(en_q), csr_wdata));
    end else if (csr_we && (csr_sel == CSR_MODE)) begin
      mode_d = IRQ_LINES'(csr_apply(csr_op, CSR_W'(mode_q), csr_wdata));
    end else if (csr_we && (csr_sel == CSR_PENDING)) begin
      sw_pend_s = IRQ_LINES'(csr_apply(csr_op, CSR_W'(pend_q), csr_wdata));
    end else begin
      sw_pend_s = pend_q;
    end
    for (int i = 0; i < IRQ_LINES; i++) begin
      if (!mode_q[i]) pend_d[i] = sync_s[i];
      else if (rise_s[i]) pend_d[i] = 1'b1;
      else pend_d[i] = sw_pend_s[i];
    end
  end

  // Lowest-numbered enabled pending line wins
  always_comb begin
    active_s = pend_q & en_q;
    cand_s   = 6'd0;
    for (int i = IRQ_LINES - 1; i >= 0; i--) begin
      cand_s = active_s[i] ? 6'(i) : cand_s;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IRQC_IDLE: begin
        if ((|active_s) && mie) state_d = IRQC_REQ;
        else state_d = IRQC_IDLE;
      end
      IRQC_REQ: begin
        if (irq_ack) state_d = IRQC_SERVICE;
        else if (!(|active_s) || !mie) state_d = IRQC_IDLE;
        else state_d = IRQC_REQ;
      end
      IRQC_SERVICE: begin
        if (irq_iret) state_d = IRQC_IDLE;
        else state_d = IRQC_SERVICE;
      end
      default: state_d = IRQC_IDLE;
    endcase
  end

  // FSM outputs, registered from the next state; the index freezes once serviced
  always_comb begin
    irq_req_d    = (state_d == IRQC_REQ);
    in_service_d = (state_d == IRQC_SERVICE);
    if (state_d == IRQC_REQ) irq_idx_d = cand_s;
    else irq_idx_d = irq_idx_q;
  end

  // State, CSR and output registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IRQC_IDLE;
      pend_q       <= {IRQ_LINES{1'b0}};
      en_q         <= {IRQ_LINES{1'b0}};
      mode_q       <= {IRQ_LINES{1'b0}};
      irq_req_q    <= 1'b0;
      in_service_q <= 1'b0;
      irq_idx_q    <= 6'd0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      en_q         <= en_d;
      mode_q       <= mode_d;
      irq_req_q    <= irq_req_d;
      in_service_q <= in_service_d;
      irq_idx_q    <= irq_idx_d;
    end
  end

  // CSR read mux, zero-extended
  always_comb begin
    case (csr_sel)
      CSR_PENDING: csr_rdata = CSR_W'(pend_q);
      CSR_ENABLE:  csr_rdata = CSR_W'(en_q);
      CSR_MODE:    csr_rdata = CSR_W'(mode_q);
      default:     csr_rdata = 48'd0;
    endcase
  end

  assign irq_req    = irq_req_q;
  assign irq_idx    = irq_idx_q;
  assign in_service = in_service_q;

endmodule

// File: tb/tb_cpu_ad48_irqc.sv
// Directed bench for cpu_ad48_irqc (IRQ_LINES=4, SYNC_STAGES=2): CSR vector table
// followed by hand-written request/service/reset sequences.
module tb_cpu_ad48_irqc;

  logic        clk;
  logic        resetn;
  logic [3:0]  irq_in;
  logic        mie;
  logic        csr_we;
  logic [1:0]  csr_sel;
  logic [1:0]  csr_op;
  logic [47:0] csr_wdata;
  logic [47:0] csr_rdata;
  logic        irq_req;
  logic [5:0]  irq_idx;
  logic        irq_ack;
  logic        irq_iret;
  logic        in_service;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]  sel;
    logic [1:0]  op;
    logic [47:0] wdata;
    logic [1:0]  rd_sel;
    logic [47:0] exp;
  } vec_t;

  vec_t vecs [11];

  cpu_ad48_irqc #(.IRQ_LINES(4), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .irq_in     (irq_in),
    .mie        (mie),
    .csr_we     (csr_we),
    .csr_sel    (csr_sel),
    .csr_op     (csr_op),
    .csr_wdata  (csr_wdata),
    .csr_rdata  (csr_rdata),
    .irq_req    (irq_req),
    .irq_idx    (irq_idx),
    .irq_ack    (irq_ack),
    .irq_iret   (irq_iret),
    .in_service (in_service)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic csr_wr(input logic [1:0] sel, input logic [1:0] op, input logic [47:0] wd);
    csr_we    = 1'b1;
    csr_sel   = sel;
    csr_op    = op;
    csr_wdata = wd;
    step(1);
    csr_we    = 1'b0;
    csr_op    = 2'd3;
    csr_wdata = 48'd0;
  endtask

  task automatic rd(input logic [1:0] sel, output logic [47:0] v);
    csr_sel = sel;
    #1;
    v = csr_rdata;
  endtask

  task automatic check_outs(input string name, input logic req, input logic [5:0] idx,
                            input logic svc);
    check({name, ".irq_req"}, {47'd0, irq_req}, {47'd0, req});
    check({name, ".irq_idx"}, {42'd0, irq_idx}, {42'd0, idx});
    check({name, ".in_service"}, {47'd0, in_service}, {47'd0, svc});
  endtask

  logic [47:0] v;

  initial begin
    resetn = 1'b0; irq_in = 4'd0; mie = 1'b0; csr_we = 1'b0; csr_sel = 2'd0;
    csr_op = 2'd3; csr_wdata = 48'd0; irq_ack = 1'b0; irq_iret = 1'b0;

    // sel, op, wdata, readback sel, expected readback (4 lines)
    vecs[0]  = '{2'd1, 2'd0, 48'h5,            2'd1, 48'h5};
    vecs[1]  = '{2'd1, 2'd1, 48'h2,            2'd1, 48'h7};
    vecs[2]  = '{2'd1, 2'd2, 48'h4,            2'd1, 48'h3};
    vecs[3]  = '{2'd1, 2'd3, 48'hF,            2'd1, 48'h3};
    vecs[4]  = '{2'd3, 2'd0, 48'hF,            2'd1, 48'h3};
    vecs[5]  = '{2'd3, 2'd0, 48'hF,            2'd3, 48'h0};
    vecs[6]  = '{2'd1, 2'd0, 48'hFFFF_FFFF_FFF0, 2'd1, 48'h0};
    vecs[7]  = '{2'd2, 2'd0, 48'hA,            2'd2, 48'hA};
    vecs[8]  = '{2'd2, 2'd2, 48'h2,            2'd2, 48'h8};
    vecs[9]  = '{2'd2, 2'd1, 48'h7,            2'd2, 48'hF};
    vecs[10] = '{2'd1, 2'd0, 48'hF,            2'd1, 48'hF};

    step(2);
    resetn = 1'b1;
    check_outs("reset", 1'b0, 6'd0, 1'b0);
    for (int s = 0; s < 4; s++) begin
      rd(2'(s), v);
      check($sformatf("reset.rdata[sel=%0d]", s), v, 48'd0);
    end

    for (int i = 0; i < 11; i++) begin
      csr_wr(vecs[i].sel, vecs[i].op, vecs[i].wdata);
      rd(vecs[i].rd_sel, v);
      check($sformatf("csr_vec%0d", i), v, vecs[i].exp);
    end

    // Edge pulse on line 0: pending after 3 clocks, request one clock later
    mie = 1'b1;
    irq_in[0] = 1'b1;
    step(1);
    irq_in[0] = 1'b0;
    step(1);
    rd(2'd0, v); check("pulse.pend_early", v, 48'h0);
    step(1);
    rd(2'd0, v); check("pulse.pend", v, 48'h1);
    check("pulse.req_early", {47'd0, irq_req}, 48'd0);
    step(1);
    check_outs("pulse.req", 1'b1, 6'd0, 1'b0);

    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
    check_outs("ack", 1'b0, 6'd0, 1'b1);
    csr_wr(2'd0, 2'd2, 48'h1);

    // New edge on line 3 while in service: no nesting
    irq_in[3] = 1'b1;
    step(1);
    irq_in[3] = 1'b0;
    step(4);
    rd(2'd0, v); check("svc.pend3", v, 48'h8);
    check_outs("svc.no_req", 1'b0, 6'd0, 1'b1);
    irq_iret = 1'b1;
    step(1);
    irq_iret = 1'b0;
    check_outs("iret.t1", 1'b0, 6'd0, 1'b0);
    step(1);
    check_outs("iret.t2", 1'b1, 6'd3, 1'b0);

    // Priority tracking in REQ: lines 1,2 added, then line 1 cleared
    csr_wr(2'd0, 2'd1, 48'h6);
    step(1);
    check_outs("prio.idx1", 1'b1, 6'd1, 1'b0);
    csr_wr(2'd0, 2'd2, 48'h2);
    step(1);
    check_outs("prio.idx2", 1'b1, 6'd2, 1'b0);
    csr_wr(2'd0, 2'd2, 48'hF);
    step(1);
    check_outs("prio.drop", 1'b0, 6'd2, 1'b0);

    // Stray ack and iret in IDLE are ignored
    irq_ack = 1'b1; irq_iret = 1'b1;
    step(2);
    irq_ack = 1'b0; irq_iret = 1'b0;
    check_outs("stray", 1'b0, 6'd2, 1'b0);

    // Edge-set and software clear in the same cycle: set wins
    mie = 1'b0;
    irq_in[1] = 1'b1;
    step(2);
    csr_wr(2'd0, 2'd2, 48'h2);
    rd(2'd0, v); check("race.set_wins", v, 48'h2);
    csr_wr(2'd0, 2'd2, 48'h2);
    rd(2'd0, v); check("race.later_clear", v, 48'h0);
    irq_in[1] = 1'b0;

    // Level line 0 follows sync; software writes do nothing; mie gates the request
    csr_wr(2'd2, 2'd2, 48'h1);
    irq_in[0] = 1'b1;
    step(3);
    rd(2'd0, v); check("level.pend", v, 48'h1);
    check("level.mie_block", {47'd0, irq_req}, 48'd0);
    csr_wr(2'd0, 2'd2, 48'h1);
    rd(2'd0, v); check("level.rc_ignored", v, 48'h1);
    mie = 1'b1;
    step(1);
    check_outs("level.req", 1'b1, 6'd0, 1'b0);
    mie = 1'b0;
    step(1);
    check_outs("level.mie_drop", 1'b0, 6'd0, 1'b0);
    irq_in[0] = 1'b0;
    step(2);
    rd(2'd0, v); check("level.fall_early", v, 48'h1);
    step(1);
    rd(2'd0, v); check("level.fall", v, 48'h0);

    // Reset in SERVICE abandons everything
    mie = 1'b1;
    csr_wr(2'd0, 2'd1, 48'h4);
    step(1);
    check_outs("rst.req", 1'b1, 6'd2, 1'b0);
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
    check_outs("rst.svc", 1'b0, 6'd2, 1'b1);
    resetn = 1'b0;
    step(1);
    resetn = 1'b1;
    check_outs("rst.outs", 1'b0, 6'd0, 1'b0);
    for (int s = 0; s < 4; s++) begin
      rd(2'(s), v);
      check($sformatf("rst.rdata[sel=%0d]", s), v, 48'd0);
    end
    step(2);
    check_outs("rst.quiet", 1'b0, 6'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
